// File: rtl/bubble_host_sequencer.sv
// Host-side bubble access sequencer: seek by rotation count, replicate, skip latency, deserialise.
// Optional CRC-16-CCITT checker over captured bits is enabled by defining BUBBLE_HOST_CRC_EN.
module bubble_host_sequencer #(
  parameter int unsigned REP_TICKS    = 16,
  parameter int unsigned DATA_LATENCY = 2,
  parameter int unsigned STOP_TIMEOUT = 4095
) (
  input  logic        master_clock,
  input  logic        master_reset,
  input  logic        start,
  input  logic        boot_page,
  input  logic [11:0] skip_rotations,
  input  logic [12:0] bit_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        bubble_shift_enable,
  output logic        replicator_enable,
  output logic        bootloop_enable,
`ifdef BUBBLE_HOST_CRC_EN
  output logic [15:0] crc_out,
  output logic        crc_ok,
`endif
  input  logic        position_change,
  input  logic        coil_enable,
  input  logic        bubble_data_in,
  input  logic        bubble_data_clock
);

  localparam int unsigned ROT_W  = 12;
  localparam int unsigned BIT_W  = 13;
  localparam int unsigned REP_W  = (REP_TICKS < 2) ? 1 : $clog2(REP_TICKS + 1);
  localparam int unsigned LAT_W  = (DATA_LATENCY < 2) ? 1 : $clog2(DATA_LATENCY + 1);
  localparam int unsigned STOP_W = (STOP_TIMEOUT < 2) ? 1 : $clog2(STOP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_REPL, S_LAT, S_XFER, S_STOP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        pc_sync, coil_sync, din_sync, dclk_sync;
  logic              pc_prev, dclk_prev;
  logic              pc_stb, dat_stb, coil_s, din_s;

  logic [ROT_W-1:0]  rot_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [STOP_W-1:0] stop_cnt;
  logic [7:0]        sreg;
  logic [3:0]        nbits;

  logic [7:0]        sreg_nx;
  logic [3:0]        nb_nx;
  logic              cap, emit;

  logic              busy_d, done_d, timeout_d, byte_valid_d;
  logic              shift_en_d, rep_en_d, boot_d;
  logic [7:0]        byte_d;

  // Input synchronisers with rising-edge strobes for rotation and data clock
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      pc_sync   <= 2'b00;
      coil_sync <= 2'b11;
      din_sync  <= 2'b00;
      dclk_sync <= 2'b00;
      pc_prev   <= 1'b0;
      dclk_prev <= 1'b0;
    end else begin
      pc_sync   <= {pc_sync[0], position_change};
      coil_sync <= {coil_sync[0], coil_enable};
      din_sync  <= {din_sync[0], bubble_data_in};
      dclk_sync <= {dclk_sync[0], bubble_data_clock};
      pc_prev   <= pc_sync[1];
      dclk_prev <= dclk_sync[1];
    end
  end

  assign pc_stb  = pc_sync[1] & ~pc_prev;
  assign dat_stb = dclk_sync[1] & ~dclk_prev;
  assign coil_s  = coil_sync[1];
  assign din_s   = din_sync[1];

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_SEEK;
      S_SEEK: begin
        if (abort)                                state_nx = S_STOP;
        else if (pc_stb && (rot_cnt == '0))       state_nx = S_REPL;
      end
      S_REPL: begin
        if (abort)                                state_nx = S_STOP;
        else if (rep_cnt == REP_W'(REP_TICKS - 1))
          state_nx = (DATA_LATENCY == 0) ? S_XFER : S_LAT;
      end
      S_LAT: begin
        if (abort)                                state_nx = S_STOP;
        else if (pc_stb && (lat_cnt <= LAT_W'(1))) state_nx = S_XFER;
      end
      S_XFER: begin
        if (abort)                                state_nx = S_STOP;
        else if ((bit_cnt == '0) || (dat_stb && (bit_cnt == BIT_W'(1))))
          state_nx = S_STOP;
      end
      S_STOP: begin
        if (coil_s || (stop_cnt == STOP_W'(STOP_TIMEOUT - 1))) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit capture: a byte is emitted when full or when the last bit arrives
  assign cap     = (state == S_XFER) && !abort && dat_stb && (bit_cnt != '0);
  assign sreg_nx = {sreg[6:0], din_s};
  assign nb_nx   = nbits + 4'd1;
  assign emit    = cap && ((nb_nx == 4'd8) || (bit_cnt == BIT_W'(1)));

  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    shift_en_d   = 1'b1;
    rep_en_d     = 1'b1;
    byte_valid_d = 1'b0;
    byte_d       = byte_out;
    timeout_d    = timeout;
    boot_d       = bootloop_enable;
    unique case (state_nx)
      S_SEEK, S_REPL, S_LAT, S_XFER: begin
        busy_d     = 1'b1;
        shift_en_d = 1'b0;
      end
      S_STOP:  busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    if (state_nx == S_REPL) rep_en_d = 1'b0;
    if ((state == S_IDLE) && start) begin
      boot_d    = boot_page;
      timeout_d = 1'b0;
    end
    if ((state_nx == S_IDLE) || (state_nx == S_DONE)) boot_d = 1'b0;
    if ((state == S_STOP) && (state_nx == S_DONE) && !coil_s) timeout_d = 1'b1;
    if (emit) begin
      byte_valid_d = 1'b1;
      byte_d       = sreg_nx << (4'd8 - nb_nx);
    end
  end

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      busy                <= 1'b0;
      done                <= 1'b0;
      timeout             <= 1'b0;
      byte_out            <= 8'h00;
      byte_valid          <= 1'b0;
      bubble_shift_enable <= 1'b1;
      replicator_enable   <= 1'b1;
      bootloop_enable     <= 1'b0;
    end else begin
      busy                <= busy_d;
      done                <= done_d;
      timeout             <= timeout_d;
      byte_out            <= byte_d;
      byte_valid          <= byte_valid_d;
      bubble_shift_enable <= shift_en_d;
      replicator_enable   <= rep_en_d;
      bootloop_enable     <= boot_d;
    end
  end

  // Counters all saturate at their terminal value
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      rot_cnt  <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      lat_cnt  <= '0;
      stop_cnt <= '0;
      sreg     <= 8'h00;
      nbits    <= 4'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        rot_cnt <= skip_rotations;
        bit_cnt <= bit_count;
        sreg    <= 8'h00;
        nbits   <= 4'd0;
      end else begin
        if ((state == S_SEEK) && pc_stb && (rot_cnt != '0)) rot_cnt <= rot_cnt - ROT_W'(1);
        if (cap) begin
          bit_cnt <= bit_cnt - BIT_W'(1);
          sreg    <= sreg_nx;
          nbits   <= (nb_nx == 4'd8) ? 4'd0 : nb_nx;
        end
      end
      rep_cnt <= (state == S_REPL) ? rep_cnt + REP_W'(1) : '0;
      if (state == S_REPL) lat_cnt <= LAT_W'(DATA_LATENCY);
      else if ((state == S_LAT) && pc_stb && (lat_cnt != '0)) lat_cnt <= lat_cnt - LAT_W'(1);
      if (state != S_STOP) stop_cnt <= '0;
      else if (stop_cnt != STOP_W'(STOP_TIMEOUT - 1)) stop_cnt <= stop_cnt + STOP_W'(1);
    end
  end

`ifdef BUBBLE_HOST_CRC_EN
  // CRC-16-CCITT, MSB-first, over every captured bit
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      crc_out <= 16'hFFFF;
      crc_ok  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        crc_out <= 16'hFFFF;
        crc_ok  <= 1'b0;
      end else if (cap) begin
        crc_out <= {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ din_s) ? 16'h1021 : 16'h0000);
      end
      if ((state == S_STOP) && (state_nx == S_DONE)) crc_ok <= (crc_out == 16'h0000);
    end
  end
`endif

endmodule
